smart_stack_ops: RTL

//  Parametrised CPU data stack (successor to the fixed 16x20 stack). Caches TOS/NOS in

---
 rtl/smart_stack_ops.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/smart_stack_ops.sv
// Parametrised CPU data stack: TOS/NOS held in registers, deeper entries in a spill array.
// Optional macro SMART_STACK_STICKY_ERR_EN makes overflow/underflow sticky until NOP/reset.
module smart_stack_ops #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 20
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [2:0]                 i_function,
  input  logic [WIDTH-1:0]           i_write_D,
  output logic [WIDTH-1:0]           o_read_A,
  output logic [WIDTH-1:0]           o_read_B,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam int unsigned MEM_N = DEPTH - 2;
  localparam int unsigned AW    = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_NIP     = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [DW-1:0]    r_depth, w_depth_nxt;
  logic             r_ovf, r_unf, w_ovf, w_unf, w_clr;
  logic [WIDTH-1:0] r_mem [MEM_N];
  logic             w_mem_we;
  logic [AW-1:0]    w_wr_idx, w_rd_idx;
  logic [WIDTH-1:0] w_fill;
  logic             w_ge1, w_ge2, w_ge3, w_not_full;

  // Depth qualifiers and spill/fill addressing (mem[d-2] on grow, mem[d-3] on shrink)
  always_comb begin
    w_ge1      = (r_depth >= DW'(1));
    w_ge2      = (r_depth >= DW'(2));
    w_ge3      = (r_depth >= DW'(3));
    w_not_full = (r_depth <  DW'(DEPTH));
    w_wr_idx   = w_ge2 ? AW'(r_depth - DW'(2)) : '0;
    w_rd_idx   = w_ge3 ? AW'(r_depth - DW'(3)) : '0;
    w_fill     = w_ge3 ? r_mem[w_rd_idx] : '0;
  end

  // Op decode: next TOS/NOS/depth, spill enable and rejection flags
  always_comb begin
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_depth_nxt = r_depth;
    w_mem_we    = 1'b0;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    w_clr       = 1'b0;
    if (i_valid) begin
      case (i_function)
        OP_NOP: w_clr = 1'b1;
        OP_PUSH: begin
          if (w_not_full) begin
            w_a_nxt     = i_write_D;
            w_b_nxt     = r_a;
            w_depth_nxt = r_depth + DW'(1);
            w_mem_we    = w_ge2;
          end else w_ovf = 1'b1;
        end
        OP_DROP: begin
          if (w_ge1) begin
            w_a_nxt     = (r_depth == DW'(1)) ? '0 : r_b;
            w_b_nxt     = w_fill;
            w_depth_nxt = r_depth - DW'(1);
          end else w_unf = 1'b1;
        end
        OP_DUP: begin
          if (!w_ge1) w_unf = 1'b1;
          else if (!w_not_full) w_ovf = 1'b1;
          else begin
            w_b_nxt     = r_a;
            w_depth_nxt = r_depth + DW'(1);
            w_mem_we    = w_ge2;
          end
        end
        OP_SWAP: begin
          if (w_ge2) begin
            w_a_nxt = r_b;
            w_b_nxt = r_a;
          end else w_unf = 1'b1;
        end
        OP_OVER: begin
          if (!w_ge2) w_unf = 1'b1;
          else if (!w_not_full) w_ovf = 1'b1;
          else begin
            w_a_nxt     = r_b;
            w_b_nxt     = r_a;
            w_depth_nxt = r_depth + DW'(1);
            w_mem_we    = 1'b1;
          end
        end
        OP_NIP: begin
          if (w_ge2) begin
            w_b_nxt     = w_fill;
            w_depth_nxt = r_depth - DW'(1);
          end else w_unf = 1'b1;
        end
        OP_REPLACE: begin
          if (w_ge1) w_a_nxt = i_write_D;
          else w_unf = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_depth <= w_depth_nxt;
`ifdef SMART_STACK_STICKY_ERR_EN
      r_ovf   <= w_ovf | (r_ovf & ~w_clr);
      r_unf   <= w_unf | (r_unf & ~w_clr);
`else
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
`endif
    end
  end

  // Spill array is deliberately not reset; entries above depth are never observed
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= r_b;
  end

  assign o_read_A    = r_a;
  assign o_read_B    = r_b;
  assign o_depth     = r_depth;
  assign o_full      = (r_depth == DW'(DEPTH));
  assign o_empty     = (r_depth == '0);
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule
